// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single line-wide memory port,
// with a per-access timeout that completes the access with an error flag.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_enable,
  input  logic         r0_rw,
  input  logic [31:0]  r0_addr,
  input  logic [511:0] r0_wdata,
  output logic [511:0] r0_rdata,
  output logic         r0_ready,
  output logic         r0_err,
  input  logic         r1_enable,
  input  logic         r1_rw,
  input  logic [31:0]  r1_addr,
  input  logic [511:0] r1_wdata,
  output logic [511:0] r1_rdata,
  output logic         r1_ready,
  output logic         r1_err,
  output logic         mem_enable,
  output logic         mem_rw,
  output logic [31:0]  mem_addr,
  output logic [511:0] mem_wdata,
  input  logic [511:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt, gnt_sel;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mem_enable_nxt, mem_rw_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic [DW-1:0] r0_rdata_nxt, r1_rdata_nxt;
  logic          r0_ready_nxt, r1_ready_nxt, r0_err_nxt, r1_err_nxt;

  // State and registered outputs; last-winner resets to 1 so r0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      r0_ready   <= 1'b0;
      r1_ready   <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      mem_enable <= mem_enable_nxt;
      mem_rw     <= mem_rw_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      r0_rdata   <= r0_rdata_nxt;
      r1_rdata   <= r1_rdata_nxt;
      r0_ready   <= r0_ready_nxt;
      r1_ready   <= r1_ready_nxt;
      r0_err     <= r0_err_nxt;
      r1_err     <= r1_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    gnt_sel        = 1'b0;
    last_nxt       = last;
    cnt_nxt        = cnt;
    mem_enable_nxt = mem_enable;
    mem_rw_nxt     = mem_rw;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    r0_rdata_nxt   = r0_rdata;
    r1_rdata_nxt   = r1_rdata;
    r0_ready_nxt   = 1'b0;
    r1_ready_nxt   = 1'b0;
    r0_err_nxt     = 1'b0;
    r1_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (r0_enable || r1_enable) begin
          // On a tie the requester that did not win last goes next
          gnt_sel        = (r0_enable && r1_enable) ? ~last : r1_enable;
          gnt_nxt        = gnt_sel;
          mem_enable_nxt = 1'b1;
          mem_rw_nxt     = gnt_sel ? r1_rw    : r0_rw;
          mem_addr_nxt   = gnt_sel ? r1_addr  : r0_addr;
          mem_wdata_nxt  = gnt_sel ? r1_wdata : r0_wdata;
          cnt_nxt        = '0;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_enable_nxt = 1'b0;
          last_nxt       = gnt;
          state_nxt      = DONE;
          if (gnt) begin
            r1_ready_nxt = 1'b1;
            if (!mem_rw) r1_rdata_nxt = mem_rdata;
          end else begin
            r0_ready_nxt = 1'b1;
            if (!mem_rw) r0_rdata_nxt = mem_rdata;
          end
        end else if (cnt == CW'(TIMEOUT)) begin
          mem_enable_nxt = 1'b0;
          last_nxt       = gnt;
          state_nxt      = DONE;
          if (gnt) begin
            r1_ready_nxt = 1'b1;
            r1_err_nxt   = 1'b1;
          end else begin
            r0_ready_nxt = 1'b1;
            r0_err_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
